// File: rtl/fme_satd_sched_pkg.sv
// Shared definitions for the FME SATD scheduler slice.
//  - PU mode encodings driven on pu_sel
//  - scheduler state encoding
//  - residual row type (4 pixels x 9 bit, element 0 = column 0)
//  - default widths for the PU column sum and the candidate cost
package fme_satd_sched_pkg;

  localparam int unsigned SUM_W_DEF  = 16;
  localparam int unsigned COST_W_DEF = 20;
  localparam int unsigned PIX_W      = 9;
  localparam int unsigned ROW_PIX    = 4;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_DRAIN = 2'b10;
  localparam logic [1:0] SEL_CLR   = 2'b11;

  // Encodings are fixed so they match the legacy state register values.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ACC   = 3'd4,
    ST_CMP   = 3'd5,
    ST_DONE  = 3'd6,
    ST_ABORT = 3'd7
  } state_e;

  typedef logic [ROW_PIX-1:0][PIX_W-1:0] row_t;

endpackage

// File: rtl/fme_satd_sched_if.sv
// Residual-buffer and SATD PU bus of the FME scheduler.
//  master (scheduler): drives pix_req/pix_cand/pix_blk/pix_row, pu_sel, pu_rc;
//                      receives pix_valid, pix_diff, pu_sum.
//  slave  (buffer/PU): the mirror image.
interface fme_satd_sched_if
  import fme_satd_sched_pkg::*;
#(
  parameter int unsigned SUM_W = SUM_W_DEF
);
  logic             pix_req;
  logic [3:0]       pix_cand;
  logic [3:0]       pix_blk;
  logic [1:0]       pix_row;
  logic             pix_valid;
  row_t             pix_diff;
  logic [1:0]       pu_sel;
  row_t             pu_rc;
  logic [SUM_W-1:0] pu_sum;

  modport master (
    output pix_req, pix_cand, pix_blk, pix_row, pu_sel, pu_rc,
    input  pix_valid, pix_diff, pu_sum
  );

  modport slave (
    input  pix_req, pix_cand, pix_blk, pix_row, pu_sel, pu_rc,
    output pix_valid, pix_diff, pu_sum
  );
endinterface

// File: rtl/fme_satd_sched_best_cand.sv
// Best-candidate register for the FME SATD scheduler.
//  clk, rst      clock, async active-low reset
//  init_i        reset best to idx 0 / cost all-ones and forget any winner
//  upd_i         offer (idx_i, cost_i); taken if it is the first offer since
//                init or strictly cheaper than the current best
//  best_idx_o    winning candidate index
//  best_cost_o   winning cost
module fme_best_cand #(
  parameter int unsigned COST_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_i,
  input  logic              upd_i,
  input  logic [3:0]        idx_i,
  input  logic [COST_W-1:0] cost_i,
  output logic [3:0]        best_idx_o,
  output logic [COST_W-1:0] best_cost_o
);

  logic [3:0]        idx_q,  idx_d;
  logic [COST_W-1:0] cost_q, cost_d;
  logic              have_q, have_d;

  // have_q lets a saturated (all-ones) first candidate still win.
  always_comb begin
    idx_d  = idx_q;
    cost_d = cost_q;
    have_d = have_q;
    if (init_i) begin
      idx_d  = '0;
      cost_d = '1;
      have_d = 1'b0;
    end else if (upd_i && (!have_q || (cost_i < cost_q))) begin
      idx_d  = idx_i;
      cost_d = cost_i;
      have_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      cost_q <= '1;
      have_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cost_q <= cost_d;
      have_q <= have_d;
    end
  end

  assign best_idx_o  = idx_q;
  assign best_cost_o = cost_q;

endmodule

// File: rtl/fme_satd_sched.sv
// Scheduler for the shared 4x4 Hadamard SATD PU in the FME stage.
// For each enabled candidate it fetches NUM_BLK 4x4 residual blocks row by
// row, runs the PU through clear/load/drain, accumulates the halved SATD per
// candidate, adds the MV cost and tracks the cheapest candidate.
//  clk, rst       clock, async active-low reset
//  start_i        1-cycle start pulse, ignored while busy
//  abort_i        synchronous abort back to idle (wins over everything)
//  cand_en_i      candidate enable mask, sampled on accepted start
//  lambda_mv_i    MV cost for candidates != 0, sampled on accepted start
//  bus            residual request / PU control bus (master side)
//  busy_o         search in progress (through the done cycle)
//  done_o         1-cycle completion pulse
//  best_idx_o     winning candidate
//  best_cost_o    winning cost
module fme_satd_sched
  import fme_satd_sched_pkg::*;
#(
  parameter int unsigned NUM_CAND = 9,
  parameter int unsigned NUM_BLK  = 4,
  parameter int unsigned SUM_W    = SUM_W_DEF,
  parameter int unsigned COST_W   = COST_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [NUM_CAND-1:0] cand_en_i,
  input  logic [7:0]          lambda_mv_i,
  fme_satd_sched_if.master    bus,
  output logic                busy_o,
  output logic                done_o,
  output logic [3:0]          best_idx_o,
  output logic [COST_W-1:0]   best_cost_o
);

  localparam int unsigned BLK_ACC_W = SUM_W + 2;
  localparam int unsigned ACC_W     = ((COST_W > BLK_ACC_W) ? COST_W : BLK_ACC_W) + 1;

  state_e                state_q,    state_d;
  logic [1:0]            row_q,      row_d;
  logic [3:0]            blk_q,      blk_d;
  logic [3:0]            cand_q,     cand_d;
  logic [NUM_CAND-1:0]   en_q,       en_d;
  logic [7:0]            lambda_q,   lambda_d;
  logic [BLK_ACC_W-1:0]  blk_acc_q,  blk_acc_d;
  logic [COST_W-1:0]     cand_acc_q, cand_acc_d;

  logic                  accept;
  logic [NUM_CAND-1:0]   srch_mask;
  logic                  nxt_found;
  logic [3:0]            nxt_idx;
  logic [BLK_ACC_W-1:0]  blk_half;
  logic [ACC_W-1:0]      acc_sum;
  logic [COST_W-1:0]     acc_sat;
  logic [COST_W:0]       cost_sum;
  logic [COST_W-1:0]     cost_sat;
  logic                  best_init;
  logic                  best_upd;

  assign accept = (state_q == ST_LOAD) && bus.pix_valid && !abort_i;

  // Next enabled candidate: from the live mask when starting, otherwise the
  // sampled mask above the current index. Lowest index wins.
  always_comb begin
    srch_mask = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (state_q == ST_CMP) srch_mask[i] = en_q[i] && (i > 32'(cand_q));
      else                   srch_mask[i] = cand_en_i[i];
    end
    nxt_found = |srch_mask;
    nxt_idx   = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (srch_mask[NUM_CAND-1-i]) nxt_idx = 4'(NUM_CAND-1-i);
    end
  end

  // (blk_acc + 1) >> 1 rewritten as (blk_acc >> 1) + lsb: no carry bit needed.
  assign blk_half = {1'b0, blk_acc_q[BLK_ACC_W-1:1]} + {{(BLK_ACC_W-1){1'b0}}, blk_acc_q[0]};
  assign acc_sum  = ACC_W'(cand_acc_q) + ACC_W'(blk_half);
  assign acc_sat  = (|acc_sum[ACC_W-1:COST_W]) ? '1 : acc_sum[COST_W-1:0];

  assign cost_sum = {1'b0, cand_acc_q} + ((cand_q != 4'd0) ? (COST_W+1)'(lambda_q) : '0);
  assign cost_sat = cost_sum[COST_W] ? '1 : cost_sum[COST_W-1:0];

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    blk_d      = blk_q;
    cand_d     = cand_q;
    en_d       = en_q;
    lambda_d   = lambda_q;
    blk_acc_d  = blk_acc_q;
    cand_acc_d = cand_acc_q;
    best_init  = 1'b0;
    best_upd   = 1'b0;

    if (abort_i) begin
      state_d    = ST_ABORT;
      row_d      = '0;
      blk_d      = '0;
      cand_d     = '0;
      blk_acc_d  = '0;
      cand_acc_d = '0;
      best_init  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ABORT: begin
          state_d = ST_IDLE;
          if (start_i) begin
            en_d       = cand_en_i;
            lambda_d   = lambda_mv_i;
            row_d      = '0;
            blk_d      = '0;
            blk_acc_d  = '0;
            cand_acc_d = '0;
            best_init  = 1'b1;
            cand_d     = nxt_found ? nxt_idx : 4'd0;
            state_d    = nxt_found ? ST_CLEAR : ST_DONE;
          end
        end
        ST_CLEAR: begin
          blk_acc_d = '0;
          row_d     = '0;
          state_d   = ST_LOAD;
        end
        ST_LOAD: begin
          if (accept) begin
            row_d = row_q + 2'd1;
            if (row_q == 2'd3) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          blk_acc_d = blk_acc_q + BLK_ACC_W'(bus.pu_sum);
          row_d     = row_q + 2'd1;
          if (row_q == 2'd3) state_d = ST_ACC;
        end
        ST_ACC: begin
          cand_acc_d = acc_sat;
          if (blk_q == 4'(NUM_BLK-1)) begin
            blk_d   = '0;
            state_d = ST_CMP;
          end else begin
            blk_d   = blk_q + 4'd1;
            state_d = ST_CLEAR;
          end
        end
        ST_CMP: begin
          best_upd   = 1'b1;
          cand_acc_d = '0;
          if (nxt_found) begin
            cand_d  = nxt_idx;
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          cand_d  = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      blk_q      <= '0;
      cand_q     <= '0;
      en_q       <= '0;
      lambda_q   <= '0;
      blk_acc_q  <= '0;
      cand_acc_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      blk_q      <= blk_d;
      cand_q     <= cand_d;
      en_q       <= en_d;
      lambda_q   <= lambda_d;
      blk_acc_q  <= blk_acc_d;
      cand_acc_q <= cand_acc_d;
    end
  end

  fme_best_cand #(.COST_W(COST_W)) u_best (
    .clk         (clk),
    .rst         (rst),
    .init_i      (best_init),
    .upd_i       (best_upd),
    .idx_i       (cand_q),
    .cost_i      (cost_sat),
    .best_idx_o  (best_idx_o),
    .best_cost_o (best_cost_o)
  );

  always_comb begin
    unique case (state_q)
      ST_CLEAR, ST_ABORT: bus.pu_sel = SEL_CLR;
      ST_LOAD:            bus.pu_sel = accept ? SEL_LOAD : SEL_HOLD;
      ST_DRAIN:           bus.pu_sel = SEL_DRAIN;
      default:            bus.pu_sel = SEL_HOLD;
    endcase
  end

  assign bus.pix_req  = (state_q == ST_LOAD);
  assign bus.pix_cand = cand_q;
  assign bus.pix_blk  = blk_q;
  assign bus.pix_row  = row_q;
  assign bus.pu_rc    = bus.pix_diff;

  assign busy_o = (state_q != ST_IDLE) && (state_q != ST_ABORT);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_fme_satd_sched.sv
module tb_fme_satd_sched;
  import fme_satd_sched_pkg::*;

  localparam int unsigned NC = 9;
  localparam int unsigned CW = 20;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, abort, sel_big, pix_valid;
  logic [NC-1:0] cand_en;
  logic [7:0]    lambda;
  row_t          pix_diff;
  logic [15:0]   psum [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]    idx;
    logic [CW-1:0] cost;
    int            lat;
  } exp_t;
  exp_t sb[$];

  fme_satd_sched_if #(.SUM_W(16)) bus_a ();
  fme_satd_sched_if #(.SUM_W(16)) bus_b ();

  assign bus_a.pix_valid = pix_valid;
  assign bus_a.pix_diff  = pix_diff;
  assign bus_a.pu_sum    = psum[bus_a.pix_cand];
  assign bus_b.pix_valid = pix_valid;
  assign bus_b.pix_diff  = pix_diff;
  assign bus_b.pu_sum    = psum[bus_b.pix_cand];

  logic          busy_a, done_a, busy_b, done_b;
  logic [3:0]    idx_a, idx_b;
  logic [CW-1:0] cost_a, cost_b;

  fme_satd_sched #(.NUM_CAND(NC), .NUM_BLK(4), .SUM_W(16), .COST_W(CW)) u_dut (
    .clk(clk), .rst(rst), .start_i(start & ~sel_big), .abort_i(abort),
    .cand_en_i(cand_en), .lambda_mv_i(lambda), .bus(bus_a),
    .busy_o(busy_a), .done_o(done_a), .best_idx_o(idx_a), .best_cost_o(cost_a)
  );

  fme_satd_sched #(.NUM_CAND(NC), .NUM_BLK(16), .SUM_W(16), .COST_W(CW)) u_dut16 (
    .clk(clk), .rst(rst), .start_i(start & sel_big), .abort_i(abort),
    .cand_en_i(cand_en), .lambda_mv_i(lambda), .bus(bus_b),
    .busy_o(busy_b), .done_o(done_b), .best_idx_o(idx_b), .best_cost_o(cost_b)
  );

  logic          o_busy, o_done, o_req;
  logic [3:0]    o_idx, o_cand;
  logic [CW-1:0] o_cost;
  logic [1:0]    o_sel;
  assign o_busy = sel_big ? busy_b : busy_a;
  assign o_done = sel_big ? done_b : done_a;
  assign o_idx  = sel_big ? idx_b  : idx_a;
  assign o_cost = sel_big ? cost_b : cost_a;
  assign o_req  = sel_big ? bus_b.pix_req  : bus_a.pix_req;
  assign o_cand = sel_big ? bus_b.pix_cand : bus_a.pix_cand;
  assign o_sel  = sel_big ? bus_b.pu_sel   : bus_a.pu_sel;

  // Reference: per block four drain cycles of psum[c], halved with rounding,
  // saturating per block; then lambda for c != 0; strict-less, first wins.
  function automatic void model(input logic [NC-1:0] m, input logic [7:0] lam,
                                input int nblk, output logic [3:0] bi,
                                output logic [CW-1:0] bc, output int lat);
    longint acc;
    longint maxv;
    int     n;
    bit     first;
    maxv  = longint'(CMAX);
    n     = 0;
    first = 1'b1;
    bi    = '0;
    bc    = CMAX;
    for (int c = 0; c < int'(NC); c++) begin
      if (m[c]) begin
        n++;
        acc = 0;
        for (int b = 0; b < nblk; b++) begin
          acc += (4 * longint'(psum[c]) + 1) / 2;
          if (acc > maxv) acc = maxv;
        end
        if (c != 0) begin
          acc += longint'(lam);
          if (acc > maxv) acc = maxv;
        end
        if (first || acc < longint'(bc)) begin
          bi = 4'(c);
          bc = CW'(acc);
        end
        first = 1'b0;
      end
    end
    lat = 1 + n * (10 * nblk + 1);
  endfunction

  task automatic set_psum(input logic [15:0] v);
    for (int i = 0; i < 16; i++) psum[i] = v;
  endtask

  // One search: push expectation, pulse start at a falling edge, count cycles
  // to done, pop and compare.
  task automatic run(input string name, input logic [NC-1:0] mask, input logic [7:0] lam,
                     input bit stall, input bit restart_mid, input bit big, input int nblk);
    exp_t e;
    int   k;
    int   stalls;
    bit   seen_done, bad_cand, bad_stall;
    stalls = 0; seen_done = 0; bad_cand = 0; bad_stall = 0;
    model(mask, lam, nblk, e.idx, e.cost, e.lat);
    sb.push_back(e);
    sel_big = big;
    cand_en = mask;
    lambda  = lam;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cand_en = ~mask;
    lambda  = ~lam;
    k = 1;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, o_busy);
    end
    while (!seen_done && k < 5000) begin
      pix_valid = 1'b1;
      if (stall && o_req && stalls < 37 && $urandom_range(1, 0) == 1) begin
        pix_valid = 1'b0;
        stalls++;
      end
      #1;
      if (o_req && !mask[o_cand]) bad_cand = 1'b1;
      if (!pix_valid && o_req && o_sel !== SEL_HOLD) bad_stall = 1'b1;
      if (o_done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        if (restart_mid && k == 50) begin
          start   = 1'b1;
          cand_en = mask;
        end
        @(negedge clk);
        start = 1'b0;
        k++;
      end
    end
    pix_valid = 1'b1;
    e = sb.pop_front();
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles, expected at %0d", name, k, e.lat + stalls);
    end else begin
      if (k != e.lat + stalls) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", name, k, e.lat + stalls);
      end
      checks++;
      if (o_idx !== e.idx) begin
        errors++;
        $display("FAIL %s best_idx: got %0d expected %0d", name, o_idx, e.idx);
      end
      checks++;
      if (o_cost !== e.cost) begin
        errors++;
        $display("FAIL %s best_cost: got %h expected %h", name, o_cost, e.cost);
      end
    end
    checks++;
    if (bad_cand) begin
      errors++;
      $display("FAIL %s disabled_cand_req: got 1 expected 0", name);
    end
    checks++;
    if (bad_stall) begin
      errors++;
      $display("FAIL %s pu_sel_in_stall: got non-hold expected %b", name, SEL_HOLD);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, o_done, o_busy);
    end
    checks++;
    if (o_cost !== e.cost || o_idx !== e.idx) begin
      errors++;
      $display("FAIL %s best_hold: got %0d/%h expected %0d/%h", name, o_idx, o_cost, e.idx, e.cost);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; sel_big = 1'b0; pix_valid = 1'b1;
    cand_en = '0; lambda = '0; pix_diff = {9'h1F0, 9'h0A5, 9'h103, 9'h00F};
    set_psum(16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done: got %b %b expected 0 0", busy_a, done_a);
    end
    checks++;
    if (idx_a !== 4'd0 || cost_a !== CMAX) begin
      errors++;
      $display("FAIL reset_best: got %0d/%h expected 0/%h", idx_a, cost_a, CMAX);
    end
    checks++;
    if (bus_a.pu_sel !== SEL_HOLD || bus_a.pix_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: got sel=%b req=%b expected 00 0", bus_a.pu_sel, bus_a.pix_req);
    end
    checks++;
    if (bus_a.pu_rc !== pix_diff) begin
      errors++;
      $display("FAIL pu_rc_passthru: got %h expected %h", bus_a.pu_rc, pix_diff);
    end
  endtask

  task automatic test_zero_sum();
    set_psum(16'd0);
    run("zero_sum", 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 4);
  endtask

  task automatic test_min_search();
    set_psum(16'd8);
    psum[5] = 16'd1;
    run("min_search", 9'h1FF, 8'd4, 1'b0, 1'b0, 1'b0, 4);
  endtask

  task automatic test_tie();
    set_psum(16'd8);
    run("tie_low_index", 9'h1FF, 8'd0, 1'b0, 1'b1, 1'b0, 4);
  endtask

  task automatic test_sparse_mask();
    set_psum(16'd8);
    psum[2] = 16'd3;
    run("single_cand", 9'h004, 8'd7, 1'b0, 1'b0, 1'b0, 4);
    run("empty_mask", 9'h000, 8'd7, 1'b0, 1'b0, 1'b0, 4);
  endtask

  task automatic test_stalls();
    set_psum(16'd8);
    psum[5] = 16'd1;
    run("stalls", 9'h1FF, 8'd4, 1'b1, 1'b0, 1'b0, 4);
  endtask

  task automatic test_saturation();
    set_psum(16'hFFFF);
    run("sat_single", 9'h001, 8'd0, 1'b0, 1'b0, 1'b1, 16);
    run("sat_tie", 9'h009, 8'd5, 1'b0, 1'b0, 1'b1, 16);
    sel_big = 1'b0;
  endtask

  task automatic test_abort();
    int  k;
    bit  got_done;
    set_psum(16'd8);
    sel_big = 1'b0;
    cand_en = 9'h1FF;
    lambda  = 8'd3;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (bus_a.pu_sel !== SEL_DRAIN && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (bus_a.pu_sel !== SEL_DRAIN) begin
      errors++;
      $display("FAIL abort_reach_drain: got sel=%b expected %b", bus_a.pu_sel, SEL_DRAIN);
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (bus_a.pu_sel !== SEL_CLR || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: got sel=%b busy=%b done=%b expected 11 0 0", bus_a.pu_sel, busy_a, done_a);
    end
    @(negedge clk);
    checks++;
    if (bus_a.pu_sel !== SEL_HOLD || busy_a !== 1'b0 || bus_a.pix_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got sel=%b busy=%b req=%b expected 00 0 0", bus_a.pu_sel, busy_a, bus_a.pix_req);
    end
    got_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_a === 1'b1 || busy_a === 1'b1) got_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (got_done) begin
      errors++;
      $display("FAIL abort_no_done: got activity after abort expected none");
    end
    checks++;
    if (idx_a !== 4'd0 || cost_a !== CMAX) begin
      errors++;
      $display("FAIL abort_best_init: got %0d/%h expected 0/%h", idx_a, cost_a, CMAX);
    end
    run("restart_after_abort", 9'h1FF, 8'd0, 1'b0, 1'b0, 1'b0, 4);
  endtask

  task automatic test_back_to_back();
    set_psum(16'd8);
    psum[7] = 16'd2;
    run("b2b_first", 9'h0F0, 8'd1, 1'b0, 1'b0, 1'b0, 4);
    psum[3] = 16'd0;
    run("b2b_second", 9'h00A, 8'd9, 1'b0, 1'b0, 1'b0, 4);
  endtask

  initial begin
    test_reset();
    test_zero_sum();
    test_min_search();
    test_tie();
    test_sparse_mask();
    test_stalls();
    test_saturation();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
